// File: rtl/nzcv_cond_unit_if.sv
// Bundle of the flag-write, branch-request and branch-result signals of the
// NZCV condition unit. The unit takes the slave side; the master modport is
// for the ALU/branch front end (or a testbench) that drives it.
// The optional taken-branch counter appears only when NZCV_TAKEN_CNT_EN is defined.
interface nzcv_cond_unit_if #(
    parameter int N = 64
);
    // Flag write side (from ALU)
    logic [3:0]   i_nzcv;
    logic         i_flags_we;
    logic         i_flags_pending;
    // Branch request
    logic         i_br_valid;
    logic         o_br_ready;
    logic [3:0]   i_br_cond;
    logic [N-1:0] i_br_pc;
    logic [N-1:0] i_br_imm;
    // Branch result
    logic         o_res_valid;
    logic         i_res_ready;
    logic         o_taken;
    logic [N-1:0] o_target;
    // Architectural flags
    logic [3:0]   o_flags;
`ifdef NZCV_TAKEN_CNT_EN
    logic [31:0]  o_taken_cnt;
`endif

    modport master (
        output i_nzcv, i_flags_we, i_flags_pending,
        output i_br_valid, i_br_cond, i_br_pc, i_br_imm,
        output i_res_ready,
        input  o_br_ready, o_res_valid, o_taken, o_target, o_flags
`ifdef NZCV_TAKEN_CNT_EN
        , input o_taken_cnt
`endif
    );

    modport slave (
        input  i_nzcv, i_flags_we, i_flags_pending,
        input  i_br_valid, i_br_cond, i_br_pc, i_br_imm,
        input  i_res_ready,
        output o_br_ready, o_res_valid, o_taken, o_target, o_flags
`ifdef NZCV_TAKEN_CNT_EN
        , output o_taken_cnt
`endif
    );
endinterface

// File: rtl/nzcv_cond_unit.sv
// nzcv_cond_unit: holds the architectural NZCV flags written by the ALU and
// resolves conditional branches against them. A branch is accepted in IDLE,
// parked in WAIT while a flag-setting op is still in flight, and its
// taken/target result is offered in RESP until the consumer takes it.
// Flag writes bypass straight into the evaluation of the same cycle.
// Optional feature: define NZCV_TAKEN_CNT_EN to add o_taken_cnt, a 32-bit
// wrapping count of taken branches handed to the consumer.
module nzcv_cond_unit #(
    parameter int N = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    nzcv_cond_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          flags_q, flags_d;
    logic [3:0]          cond_q, cond_d;
    logic [N-1:0]        pc_q, pc_d;
    logic signed [N-1:0] imm_q, imm_d;
    logic                taken_q, taken_d;
    logic [N-1:0]        target_q, target_d;

    // Evaluation operands: live request in IDLE, latched request in WAIT
    logic [3:0]          flags_eff;
    logic [3:0]          ev_cond;
    logic [N-1:0]        ev_pc;
    logic signed [N-1:0] ev_imm;
    logic                ev_taken;
    logic [N-1:0]        ev_target;

    // Condition code evaluation against {N,Z,C,V}
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        logic pass;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'h0:    pass = z;
            4'h1:    pass = !z;
            4'h2:    pass = c;
            4'h3:    pass = !c;
            4'h4:    pass = n;
            4'h5:    pass = !n;
            4'h6:    pass = v;
            4'h7:    pass = !v;
            4'h8:    pass = c && !z;
            4'h9:    pass = !c || z;
            4'hA:    pass = (n == v);
            4'hB:    pass = (n != v);
            4'hC:    pass = !z && (n == v);
            4'hD:    pass = z || (n != v);
            default: pass = 1'b1;   // AL and NV both always execute
        endcase
        return pass;
    endfunction

    // Next PC: branch target or fall-through, wrapping modulo 2^N
    function automatic logic [N-1:0] next_pc(input logic [N-1:0] pc,
                                             input logic signed [N-1:0] imm,
                                             input logic taken);
        logic [N-1:0] nxt;
        if (taken) begin
            nxt = pc + $unsigned(imm);
        end else begin
            nxt = pc + N'(4);
        end
        return nxt;
    endfunction

    // Operand selection and evaluation shared by IDLE and WAIT
    always_comb begin
        flags_eff = bus.i_flags_we ? bus.i_nzcv : flags_q;
        ev_cond   = cond_q;
        ev_pc     = pc_q;
        ev_imm    = imm_q;
        if (state_q == ST_IDLE) begin
            ev_cond = bus.i_br_cond;
            ev_pc   = bus.i_br_pc;
            ev_imm  = $signed(bus.i_br_imm);
        end
        ev_taken  = cond_pass(ev_cond, flags_eff);
        ev_target = next_pc(ev_pc, ev_imm, ev_taken);
    end

    // Next-state, request capture and result capture
    always_comb begin
        state_d  = state_q;
        flags_d  = flags_q;
        cond_d   = cond_q;
        pc_d     = pc_q;
        imm_d    = imm_q;
        taken_d  = taken_q;
        target_d = target_q;

        // Flag writes land in every state
        if (bus.i_flags_we) begin
            flags_d = bus.i_nzcv;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_br_valid) begin
                    cond_d = bus.i_br_cond;
                    pc_d   = bus.i_br_pc;
                    imm_d  = $signed(bus.i_br_imm);
                    if (bus.i_flags_pending) begin
                        state_d = ST_WAIT;
                    end else begin
                        taken_d  = ev_taken;
                        target_d = ev_target;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                // Pending dominates a simultaneous flag write
                if (!bus.i_flags_pending) begin
                    taken_d  = ev_taken;
                    target_d = ev_target;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.i_res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control, flag and result registers with asynchronous reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            flags_q  <= 4'b0000;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            taken_q  <= taken_d;
            target_q <= target_d;
        end
    end

    // Latched branch request; only meaningful after acceptance, so no reset
    always_ff @(posedge i_clk) begin
        cond_q <= cond_d;
        pc_q   <= pc_d;
        imm_q  <= imm_d;
    end

    assign bus.o_br_ready  = (state_q == ST_IDLE) && !i_rst;
    assign bus.o_res_valid = (state_q == ST_RESP);
    assign bus.o_taken     = taken_q;
    assign bus.o_target    = target_q;
    assign bus.o_flags     = flags_q;

`ifdef NZCV_TAKEN_CNT_EN
    logic [31:0] taken_cnt_q, taken_cnt_d;

    // Count taken results at the moment the consumer accepts them
    always_comb begin
        taken_cnt_d = taken_cnt_q;
        if ((state_q == ST_RESP) && bus.i_res_ready && taken_q) begin
            taken_cnt_d = taken_cnt_q + 32'd1;
        end
    end

    // Taken counter register, wraps naturally at 2^32
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            taken_cnt_q <= 32'd0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign bus.o_taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_nzcv_cond_unit.sv
// Testbench for nzcv_cond_unit: directed scenarios followed by randomized
// traffic, all checked by a scoreboard fed from a transaction-level model.
module tb_nzcv_cond_unit;
    localparam int N = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nzcv_cond_unit_if #(.N(N)) bus();

    nzcv_cond_unit #(.N(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        taken;
        logic [63:0] target;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    bit          m_busy  = 1'b0;
    bit          m_wait  = 1'b0;
    bit          m_avail = 1'b0;
    bit          m_taken = 1'b0;
    logic [3:0]  m_flags = 4'b0000;
    logic [3:0]  m_cond  = 4'h0;
    logic [63:0] m_pc    = '0;
    logic [63:0] m_imm   = '0;
    logic [31:0] exp_cnt = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Condition codes come in complementary pairs; bit 0 inverts the base test
    function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, b;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy && !z;
            3'd5: b = (n == v);
            3'd6: b = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !b : b;
    endfunction

    function automatic void resolve(input logic [3:0] eff);
        exp_t e;
        e.taken  = ref_pass(m_cond, eff);
        e.target = e.taken ? (m_pc + m_imm) : (m_pc + 64'd4);
        exp_q.push_back(e);
        m_taken = e.taken;
        m_avail = 1'b1;
        m_wait  = 1'b0;
    endfunction

    // Transaction-level model: one outstanding branch, resolved once no flag op is pending
    always @(posedge clk or posedge rst) begin
        logic [3:0] eff;
        if (rst) begin
            m_busy  = 1'b0;
            m_wait  = 1'b0;
            m_avail = 1'b0;
            m_flags = 4'b0000;
            exp_cnt = 32'd0;
            exp_q.delete();
        end else begin
            eff = bus.i_flags_we ? bus.i_nzcv : m_flags;
            if (m_avail) begin
                if (bus.i_res_ready) begin
                    m_avail = 1'b0;
                    m_busy  = 1'b0;
                    if (m_taken) exp_cnt = exp_cnt + 32'd1;
                end
            end else if (m_wait) begin
                if (!bus.i_flags_pending) resolve(eff);
            end else if (bus.i_br_valid) begin
                m_cond = bus.i_br_cond;
                m_pc   = bus.i_br_pc;
                m_imm  = bus.i_br_imm;
                m_busy = 1'b1;
                if (bus.i_flags_pending) m_wait = 1'b1;
                else resolve(eff);
            end
            if (bus.i_flags_we) m_flags = bus.i_nzcv;
        end
    end

    // Monitor: compares DUT outputs against the model and the expected-result queue
    always @(negedge clk) begin
        chk("res_valid", 64'(bus.o_res_valid), 64'(m_avail));
        chk("br_ready", 64'(bus.o_br_ready), 64'(!rst && !m_busy));
        chk("flags", 64'(bus.o_flags), 64'(m_flags));
`ifdef NZCV_TAKEN_CNT_EN
        chk("taken_cnt", 64'(bus.o_taken_cnt), 64'(exp_cnt));
`endif
        if (bus.o_res_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got res_valid=1 expected no result");
            end else begin
                chk("taken", 64'(bus.o_taken), 64'(exp_q[0].taken));
                chk("target", bus.o_target, exp_q[0].target);
                if (bus.i_res_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] cond, input logic [63:0] pc, input logic [63:0] imm);
        int n = 0;
        while (!bus.o_br_ready && n < 20) begin
            tick();
            n++;
        end
        chk("issue_ready", 64'(bus.o_br_ready), 64'd1);
        bus.i_br_valid = 1'b1;
        bus.i_br_cond  = cond;
        bus.i_br_pc    = pc;
        bus.i_br_imm   = imm;
        tick();
        bus.i_br_valid = 1'b0;
    endtask

    task automatic consume(input string name, input logic exp_taken, input logic [63:0] exp_target,
                           input int hold);
        int n = 0;
        while (!bus.o_res_valid && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_valid"}, 64'(bus.o_res_valid), 64'd1);
        chk({name, "_taken"}, 64'(bus.o_taken), 64'(exp_taken));
        chk({name, "_target"}, bus.o_target, exp_target);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({name, "_hold_taken"}, 64'(bus.o_taken), 64'(exp_taken));
            chk({name, "_hold_target"}, bus.o_target, exp_target);
            chk({name, "_hold_br_ready"}, 64'(bus.o_br_ready), 64'd0);
        end
        bus.i_res_ready = 1'b1;
        tick();
        bus.i_res_ready = 1'b0;
        chk({name, "_done_valid"}, 64'(bus.o_res_valid), 64'd0);
        chk({name, "_done_br_ready"}, 64'(bus.o_br_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] cnt_before;
        bus.i_nzcv          = 4'b0000;
        bus.i_flags_we      = 1'b0;
        bus.i_flags_pending = 1'b0;
        bus.i_br_valid      = 1'b0;
        bus.i_br_cond       = 4'h0;
        bus.i_br_pc         = '0;
        bus.i_br_imm        = '0;
        bus.i_res_ready     = 1'b0;
        cnt_before          = 32'd0;

        repeat (2) tick();
        chk("rst_res_valid", 64'(bus.o_res_valid), 64'd0);
        chk("rst_br_ready", 64'(bus.o_br_ready), 64'd0);
        chk("rst_taken", 64'(bus.o_taken), 64'd0);
        chk("rst_target", bus.o_target, 64'd0);
        chk("rst_flags", 64'(bus.o_flags), 64'd0);
        rst = 1'b0;
        tick();

        // Z set via same-cycle bypass, EQ taken with 1-cycle latency
        bus.i_flags_we = 1'b1;
        bus.i_nzcv     = 4'b0100;
        issue(4'h0, 64'h1000, 64'h20);
        bus.i_flags_we = 1'b0;
        chk("t1_latency", 64'(bus.o_res_valid), 64'd1);
        consume("t1", 1'b1, 64'h1020, 0);

        // N=1, V=0: GE not taken, LT taken
        bus.i_flags_we = 1'b1;
        bus.i_nzcv     = 4'b1000;
        tick();
        bus.i_flags_we = 1'b0;
        issue(4'hA, 64'h2000, 64'h40);
        consume("t2_ge", 1'b0, 64'h2004, 0);
        issue(4'hB, 64'h2000, 64'h40);
        consume("t2_lt", 1'b1, 64'h2040, 0);

        // Pending for 3 cycles, then flag write with pending cleared resolves HI
        bus.i_flags_pending = 1'b1;
        issue(4'h8, 64'h100, 64'h10);
        for (int i = 0; i < 2; i++) begin
            chk("t3_wait_valid", 64'(bus.o_res_valid), 64'd0);
            tick();
        end
        chk("t3_wait_valid", 64'(bus.o_res_valid), 64'd0);
        bus.i_flags_pending = 1'b0;
        bus.i_flags_we      = 1'b1;
        bus.i_nzcv          = 4'b0010;
        tick();
        bus.i_flags_we = 1'b0;
        chk("t3_latency", 64'(bus.o_res_valid), 64'd1);
        consume("t3", 1'b1, 64'h110, 0);

        // Back-pressure: result held 4 cycles
        issue(4'hE, 64'h3000, 64'h8);
        consume("t4", 1'b1, 64'h3008, 4);

        // Reset while waiting on pending flags drops the branch
        bus.i_flags_pending = 1'b1;
        issue(4'h0, 64'h4000, 64'h4);
        tick();
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(bus.o_res_valid), 64'd0);
        chk("t5_rst_br_ready", 64'(bus.o_br_ready), 64'd0);
        chk("t5_rst_flags", 64'(bus.o_flags), 64'd0);
        tick();
        rst = 1'b0;
        bus.i_flags_pending = 1'b0;
        #1;
        chk("t5_post_br_ready", 64'(bus.o_br_ready), 64'd1);
        chk("t5_post_flags", 64'(bus.o_flags), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_stale", 64'(bus.o_res_valid), 64'd0);
        end

        // AL with address wrap
`ifdef NZCV_TAKEN_CNT_EN
        cnt_before = bus.o_taken_cnt;
`endif
        issue(4'hE, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20);
        consume("t6", 1'b1, 64'h10, 0);
`ifdef NZCV_TAKEN_CNT_EN
        chk("t6_cnt", 64'(bus.o_taken_cnt), 64'(cnt_before + 32'd1));
`endif

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst                 = ($urandom_range(0, 199) == 0);
            bus.i_flags_we      = ($urandom_range(0, 3) == 0);
            bus.i_nzcv          = 4'($urandom);
            bus.i_flags_pending = ($urandom_range(0, 2) == 0);
            bus.i_br_valid      = $urandom_range(0, 1) == 1;
            bus.i_br_cond       = 4'($urandom);
            bus.i_br_pc         = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) bus.i_br_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            bus.i_br_imm        = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom}
                                                              : 64'($signed(12'($urandom)));
            bus.i_res_ready     = $urandom_range(0, 1) == 1;
            tick();
        end

        // Drain
        rst                 = 1'b0;
        bus.i_br_valid      = 1'b0;
        bus.i_flags_we      = 1'b0;
        bus.i_flags_pending = 1'b0;
        bus.i_res_ready     = 1'b1;
        repeat (4) tick();
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
        chk("drain_valid", 64'(bus.o_res_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
